// File: rtl/mips_mem_pkg.sv
// Shared definitions for the data-memory path of the MIPS M stage.
//   - opcode constants for the eight load/store instructions
//   - LSU state encoding
//   - access size enum plus opcode classification helpers
package mips_mem_pkg;

    localparam logic [5:0] OP_LB  = 6'b100000;
    localparam logic [5:0] OP_LH  = 6'b100001;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_LBU = 6'b100100;
    localparam logic [5:0] OP_LHU = 6'b100101;
    localparam logic [5:0] OP_SB  = 6'b101000;
    localparam logic [5:0] OP_SH  = 6'b101001;
    localparam logic [5:0] OP_SW  = 6'b101011;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } lsuState_e;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } memSize_e;

    function automatic logic opIsLoad(input logic [5:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: return 1'b1;
            default:                             return 1'b0;
        endcase
    endfunction

    function automatic logic opIsStore(input logic [5:0] op);
        case (op)
            OP_SB, OP_SH, OP_SW: return 1'b1;
            default:             return 1'b0;
        endcase
    endfunction

    // Non-memory opcodes fall into WORD; callers qualify with opIsLoad/opIsStore.
    function automatic memSize_e opSize(input logic [5:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return BYTE;
            OP_LH, OP_LHU, OP_SH: return HALF;
            default:              return WORD;
        endcase
    endfunction

endpackage

// File: rtl/lsu_handshake_if.sv
// Datapath-side and memory-side signals of the load/store unit.
//   master : the LSU itself (consumes requests and memory responses,
//            drives stall/response/exception outputs and the memory request)
//   slave  : the environment (pipeline + data memory)
// Request side : req_valid, req_op, req_addr, req_wdata, req_flush
// Response side: stall_o, resp_valid, resp_rdata, adel, ades, bus_err
// Memory side  : mem_en, mem_wen, mem_addr, mem_wdata, mem_rdata, mem_ready
interface lsu_handshake_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic [5:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              req_flush;

    logic              stall_o;
    logic              resp_valid;
    logic [31:0]       resp_rdata;
    logic              adel;
    logic              ades;
    logic              bus_err;

    logic              mem_en;
    logic [3:0]        mem_wen;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    modport master (
        input  req_valid, req_op, req_addr, req_wdata, req_flush,
        input  mem_rdata, mem_ready,
        output stall_o, resp_valid, resp_rdata, adel, ades, bus_err,
        output mem_en, mem_wen, mem_addr, mem_wdata
    );

    modport slave (
        output req_valid, req_op, req_addr, req_wdata, req_flush,
        output mem_rdata, mem_ready,
        input  stall_o, resp_valid, resp_rdata, adel, ades, bus_err,
        input  mem_en, mem_wen, mem_addr, mem_wdata
    );
endinterface

// File: rtl/lsu_lane_align.sv
// Combinational byte-lane logic for a 32-bit little-endian data bus.
//   op       : MIPS opcode
//   addrLo   : byte address bits [1:0]
//   wdata    : right-aligned store data
//   rdata    : raw memory word
//   legal    : op is a load or store
//   isLoad   : op is a load
//   aligned  : address is naturally aligned for the access size
//   wen      : byte write enables (zero for loads and non-memory ops)
//   wdataRep : store data replicated across the lanes it may land in
//   rdataExt : selected lane, sign- or zero-extended
module lsu_lane_align
    import mips_mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [1:0]  addrLo,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic        legal,
    output logic        isLoad,
    output logic        aligned,
    output logic [3:0]  wen,
    output logic [31:0] wdataRep,
    output logic [31:0] rdataExt
);

    memSize_e    sz;
    logic        isStore;
    logic        signExt;
    logic [7:0]  byteLane;
    logic [15:0] halfLane;

    always_comb begin
        sz      = opSize(op);
        isLoad  = opIsLoad(op);
        isStore = opIsStore(op);
        legal   = isLoad | isStore;
        // LBU/LHU have opcode bit 2 set
        signExt = ~op[2];

        case (sz)
            BYTE:    aligned = 1'b1;
            HALF:    aligned = ~addrLo[0];
            default: aligned = (addrLo == 2'b00);
        endcase

        wen      = 4'b0000;
        wdataRep = wdata;
        if (isStore) begin
            case (sz)
                BYTE: begin
                    wen      = 4'b0001 << addrLo;
                    wdataRep = {4{wdata[7:0]}};
                end
                HALF: begin
                    wen      = addrLo[1] ? 4'b1100 : 4'b0011;
                    wdataRep = {2{wdata[15:0]}};
                end
                default: wen = 4'b1111;
            endcase
        end

        case (addrLo)
            2'd0:    byteLane = rdata[7:0];
            2'd1:    byteLane = rdata[15:8];
            2'd2:    byteLane = rdata[23:16];
            default: byteLane = rdata[31:24];
        endcase
        halfLane = addrLo[1] ? rdata[31:16] : rdata[15:0];

        case (sz)
            BYTE:    rdataExt = {{24{signExt & byteLane[7]}}, byteLane};
            HALF:    rdataExt = {{16{signExt & halfLane[15]}}, halfLane};
            default: rdataExt = rdata;
        endcase
    end

endmodule

// File: rtl/lsu_handshake.sv
// Multi-cycle handshaked load/store unit for the M stage.
//   clk, rst : system clock, synchronous active-high reset
//   bus      : request, response and memory signals (lsu_handshake_if.master)
//
// state  | meaning
// IDLE   | waiting for a memory instruction; alignment checked here
// ACCESS | memory request held on the bus until mem_ready or timeout
// RESP   | one-cycle resp_valid for a completed, non-cancelled access
module lsu_handshake
    import mips_mem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 5
) (
    input  logic            clk,
    input  logic            rst,
    lsu_handshake_if.master bus
);

    lsuState_e         state;
    lsuState_e         nextState;

    logic [5:0]        opQ;
    logic [ADDR_W-1:0] addrQ;
    logic [31:0]       wdataQ;
    logic [CNT_W-1:0]  cnt;
    logic              cancelQ;
    logic [31:0]       rdataQ;
    logic              adelQ;
    logic              adesQ;
    logic              busErrQ;

    logic [5:0]        alignOp;
    logic [1:0]        alignAddrLo;
    logic [31:0]       alignWdata;
    logic              opLegal;
    logic              opLoad;
    logic              addrAligned;
    logic [3:0]        laneWen;
    logic [31:0]       laneWdata;
    logic [31:0]       laneRdata;

    logic              reqLive;
    logic              accept;
    logic              misalign;
    logic              cancelNow;
    logic              timeoutHit;

    // One lane-align instance serves both phases: in IDLE it checks the
    // incoming request, in ACCESS/RESP it works from the latched request so
    // wen/wdata stay stable and read extraction uses the latched lanes.
    always_comb begin
        if (state == IDLE) begin
            alignOp     = bus.req_op;
            alignAddrLo = bus.req_addr[1:0];
            alignWdata  = bus.req_wdata;
        end else begin
            alignOp     = opQ;
            alignAddrLo = addrQ[1:0];
            alignWdata  = wdataQ;
        end
    end

    lsu_lane_align uLaneAlign (
        .op       (alignOp),
        .addrLo   (alignAddrLo),
        .wdata    (alignWdata),
        .rdata    (bus.mem_rdata),
        .legal    (opLegal),
        .isLoad   (opLoad),
        .aligned  (addrAligned),
        .wen      (laneWen),
        .wdataRep (laneWdata),
        .rdataExt (laneRdata)
    );

    assign reqLive    = (state == IDLE) && bus.req_valid && !bus.req_flush && opLegal;
    assign accept     = reqLive && addrAligned;
    assign misalign   = reqLive && !addrAligned;
    // A flush arriving in the completing cycle cancels just like an earlier one.
    assign cancelNow  = cancelQ | bus.req_flush;
    // cnt counts completed ACCESS cycles; the cycle that would make it
    // TIMEOUT_CYC is the last one the bus is waited on.
    assign timeoutHit = !bus.mem_ready && (cnt == CNT_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        case (state)
            IDLE: begin
                if (accept) nextState = ACCESS;
            end
            ACCESS: begin
                if (bus.mem_ready) begin
                    nextState = cancelNow ? IDLE : RESP;
                end else if (timeoutHit) begin
                    nextState = IDLE;
                end
            end
            RESP:    nextState = IDLE;
            default: nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            opQ     <= '0;
            addrQ   <= '0;
            wdataQ  <= '0;
            cnt     <= '0;
            cancelQ <= 1'b0;
            rdataQ  <= '0;
            adelQ   <= 1'b0;
            adesQ   <= 1'b0;
            busErrQ <= 1'b0;
        end else begin
            adelQ   <= misalign && opLoad;
            adesQ   <= misalign && !opLoad;
            busErrQ <= (state == ACCESS) && timeoutHit && !cancelNow;

            if (accept) begin
                opQ     <= bus.req_op;
                addrQ   <= bus.req_addr;
                wdataQ  <= bus.req_wdata;
                cnt     <= '0;
                cancelQ <= 1'b0;
            end

            if (state == ACCESS) begin
                cnt <= cnt + CNT_W'(1);
                if (bus.req_flush) cancelQ <= 1'b1;
                if (bus.mem_ready && !cancelNow && opLoad) rdataQ <= laneRdata;
            end
        end
    end

    always_comb begin
        bus.stall_o    = !rst && (accept || (state == ACCESS));
        bus.mem_en     = (state == ACCESS);
        bus.mem_wen    = (state == ACCESS) ? laneWen : 4'b0000;
        bus.mem_addr   = (state == ACCESS) ? {addrQ[ADDR_W-1:2], 2'b00} : '0;
        bus.mem_wdata  = (state == ACCESS) ? laneWdata : 32'h0;
        bus.resp_valid = (state == RESP);
        bus.resp_rdata = rdataQ;
        bus.adel       = adelQ;
        bus.ades       = adesQ;
        bus.bus_err    = busErrQ;
    end

endmodule

// File: tb/tb_lsu_handshake.sv
module tb_lsu_handshake;
    import mips_mem_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    logic [31:0] lastRdata = 32'h0;

    always #5 clk = ~clk;

    lsu_handshake_if #(.ADDR_W(32)) bus ();

    lsu_handshake #(
        .ADDR_W      (32),
        .TIMEOUT_CYC (16),
        .CNT_W       (5)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic idle_inputs();
        bus.req_valid = 1'b0;
        bus.req_op    = 6'b000000;
        bus.req_addr  = 32'h0;
        bus.req_wdata = 32'h0;
        bus.req_flush = 1'b0;
        bus.mem_rdata = 32'h0;
        bus.mem_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({bus.stall_o, bus.resp_valid, bus.adel, bus.ades, bus.bus_err, bus.mem_en} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got %b expected 000000",
                     {bus.stall_o, bus.resp_valid, bus.adel, bus.ades, bus.bus_err, bus.mem_en});
        end
        checks++;
        if ({bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.resp_rdata} !== 100'h0) begin
            errors++;
            $display("FAIL reset_data: wen=%b addr=%h wdata=%h rdata=%h expected all 0",
                     bus.mem_wen, bus.mem_addr, bus.mem_wdata, bus.resp_rdata);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lw_wait();
        int stallCnt = 0;
        int respCnt  = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            bus.req_valid = (i == 0);
            bus.req_op    = OP_LW;
            bus.req_addr  = 32'h0000_0010;
            bus.mem_ready = (i == 3);
            bus.mem_rdata = (i == 3) ? 32'hDEAD_BEEF : 32'h0;
            #1;
            if (bus.stall_o) stallCnt++;
            if (bus.resp_valid) begin
                respCnt++;
                checks++;
                if (bus.resp_rdata !== 32'hDEAD_BEEF) begin
                    errors++;
                    $display("FAIL lw_rdata: got %h expected deadbeef", bus.resp_rdata);
                end
            end
            if (i == 1) begin
                checks++;
                if (!(bus.mem_en === 1'b1 && bus.mem_addr === 32'h10 && bus.mem_wen === 4'b0000)) begin
                    errors++;
                    $display("FAIL lw_bus: en=%b addr=%h wen=%b expected 1/00000010/0000",
                             bus.mem_en, bus.mem_addr, bus.mem_wen);
                end
            end
        end
        idle_inputs();
        lastRdata = 32'hDEAD_BEEF;
        checks++;
        if (stallCnt != 4) begin
            errors++;
            $display("FAIL lw_stall_cycles: got %0d expected 4", stallCnt);
        end
        checks++;
        if (respCnt != 1) begin
            errors++;
            $display("FAIL lw_resp_count: got %0d expected 1", respCnt);
        end
    endtask

    task automatic test_sb();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SB;
        bus.req_addr  = 32'h0000_0103;
        bus.req_wdata = 32'h0000_00A5;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL sb_accept: stall=%b en=%b expected 1/0", bus.stall_o, bus.mem_en);
        end
        @(negedge clk);
        idle_inputs();
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (!(bus.mem_en === 1'b1 && bus.mem_wen === 4'b1000 &&
              bus.mem_wdata === 32'hA5A5_A5A5 && bus.mem_addr === 32'h0000_0100)) begin
            errors++;
            $display("FAIL sb_bus: en=%b wen=%b wdata=%h addr=%h expected 1/1000/a5a5a5a5/00000100",
                     bus.mem_en, bus.mem_wen, bus.mem_wdata, bus.mem_addr);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (!(bus.resp_valid === 1'b1 && bus.stall_o === 1'b0 && bus.mem_en === 1'b0)) begin
            errors++;
            $display("FAIL sb_resp: valid=%b stall=%b en=%b expected 1/0/0",
                     bus.resp_valid, bus.stall_o, bus.mem_en);
        end
    endtask

    task automatic test_load_extend();
        logic [5:0]  ops   [6];
        logic [31:0] addrs [6];
        logic [31:0] datas [6];
        logic [31:0] exps  [6];
        ops[0] = OP_LB;  addrs[0] = 32'h22; datas[0] = 32'h0080_0000; exps[0] = 32'hFFFF_FF80;
        ops[1] = OP_LBU; addrs[1] = 32'h22; datas[1] = 32'h0080_0000; exps[1] = 32'h0000_0080;
        ops[2] = OP_LH;  addrs[2] = 32'h32; datas[2] = 32'h8001_0000; exps[2] = 32'hFFFF_8001;
        ops[3] = OP_LHU; addrs[3] = 32'h32; datas[3] = 32'h8001_0000; exps[3] = 32'h0000_8001;
        ops[4] = OP_LB;  addrs[4] = 32'h01; datas[4] = 32'h0000_7F00; exps[4] = 32'h0000_007F;
        ops[5] = OP_LW;  addrs[5] = 32'h44; datas[5] = 32'hCAFE_F00D; exps[5] = 32'hCAFE_F00D;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = ops[k];
            bus.req_addr  = addrs[k];
            @(negedge clk);
            idle_inputs();
            bus.mem_ready = 1'b1;
            bus.mem_rdata = datas[k];
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if (bus.resp_valid !== 1'b1 || bus.resp_rdata !== exps[k]) begin
                errors++;
                $display("FAIL load_extend[%0d]: valid=%b rdata=%h expected 1/%h",
                         k, bus.resp_valid, bus.resp_rdata, exps[k]);
            end
        end
        lastRdata = 32'hCAFE_F00D;
    endtask

    task automatic test_flush_load();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'h48;
        @(negedge clk);
        idle_inputs();
        bus.req_flush = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h1111_1111;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (!(bus.resp_valid === 1'b0 && bus.stall_o === 1'b0 && bus.resp_rdata === lastRdata)) begin
            errors++;
            $display("FAIL flush_load: valid=%b stall=%b rdata=%h expected 0/0/%h",
                     bus.resp_valid, bus.stall_o, bus.resp_rdata, lastRdata);
        end
    endtask

    task automatic test_misalign();
        logic [5:0]  ops   [3];
        logic [31:0] addrs [3];
        logic [1:0]  exps  [3];
        ops[0] = OP_LH; addrs[0] = 32'h51; exps[0] = 2'b10;
        ops[1] = OP_SW; addrs[1] = 32'h52; exps[1] = 2'b01;
        ops[2] = OP_LW; addrs[2] = 32'h53; exps[2] = 2'b10;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = ops[k];
            bus.req_addr  = addrs[k];
            #1;
            checks++;
            if (bus.stall_o !== 1'b0 || bus.mem_en !== 1'b0) begin
                errors++;
                $display("FAIL misalign_stall[%0d]: stall=%b en=%b expected 0/0", k, bus.stall_o, bus.mem_en);
            end
            @(negedge clk);
            idle_inputs();
            #1;
            checks++;
            if ({bus.adel, bus.ades} !== exps[k] || bus.mem_en !== 1'b0 || bus.stall_o !== 1'b0) begin
                errors++;
                $display("FAIL misalign_pulse[%0d]: adel/ades=%b en=%b stall=%b expected %b/0/0",
                         k, {bus.adel, bus.ades}, bus.mem_en, bus.stall_o, exps[k]);
            end
            @(negedge clk);
            #1;
            checks++;
            if ({bus.adel, bus.ades, bus.mem_en} !== 3'b000) begin
                errors++;
                $display("FAIL misalign_once[%0d]: adel/ades/en=%b expected 000", k,
                         {bus.adel, bus.ades, bus.mem_en});
            end
        end
    endtask

    task automatic test_ignored();
        // non-memory opcode, flushed aligned load, flushed misaligned load
        logic [5:0]  ops    [3];
        logic [31:0] addrs  [3];
        logic        flushs [3];
        ops[0] = 6'b000000; addrs[0] = 32'h60; flushs[0] = 1'b0;
        ops[1] = OP_LW;     addrs[1] = 32'h60; flushs[1] = 1'b1;
        ops[2] = OP_LH;     addrs[2] = 32'h61; flushs[2] = 1'b1;
        for (int k = 0; k < 3; k++) begin
            int activity = 0;
            @(negedge clk);
            bus.req_valid = 1'b1;
            bus.req_op    = ops[k];
            bus.req_addr  = addrs[k];
            bus.req_flush = flushs[k];
            for (int c = 0; c < 4; c++) begin
                #1;
                if (bus.stall_o || bus.mem_en || bus.resp_valid || bus.adel || bus.ades || bus.bus_err)
                    activity++;
                @(negedge clk);
                idle_inputs();
            end
            checks++;
            if (activity != 0) begin
                errors++;
                $display("FAIL ignored[%0d]: active cycles=%0d expected 0", k, activity);
            end
        end
    endtask

    task automatic test_timeout();
        int enCnt = 0;
        int errCnt = 0;
        int errAt = -1;
        for (int i = 0; i < 24; i++) begin
            @(negedge clk);
            bus.req_valid = (i == 0);
            bus.req_op    = OP_LW;
            bus.req_addr  = 32'h70;
            #1;
            if (bus.mem_en) enCnt++;
            if (bus.bus_err) begin
                errCnt++;
                if (errAt < 0) errAt = i;
                checks++;
                if (bus.stall_o !== 1'b0 || bus.mem_en !== 1'b0) begin
                    errors++;
                    $display("FAIL timeout_release: stall=%b en=%b expected 0/0", bus.stall_o, bus.mem_en);
                end
            end
        end
        idle_inputs();
        checks++;
        if (enCnt != 16) begin
            errors++;
            $display("FAIL timeout_access_cycles: got %0d expected 16", enCnt);
        end
        checks++;
        if (errCnt != 1 || errAt != 17) begin
            errors++;
            $display("FAIL timeout_pulse: count=%0d at=%0d expected 1 at 17", errCnt, errAt);
        end
    endtask

    task automatic test_back_to_back();
        // FSM must be back in IDLE after the timeout: a fresh SH completes.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SH;
        bus.req_addr  = 32'h0000_0082;
        bus.req_wdata = 32'hFFFF_1234;
        @(negedge clk);
        idle_inputs();
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (!(bus.mem_en === 1'b1 && bus.mem_wen === 4'b1100 &&
              bus.mem_wdata === 32'h1234_1234 && bus.mem_addr === 32'h80)) begin
            errors++;
            $display("FAIL sh_bus: en=%b wen=%b wdata=%h addr=%h expected 1/1100/12341234/00000080",
                     bus.mem_en, bus.mem_wen, bus.mem_wdata, bus.mem_addr);
        end
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.resp_valid !== 1'b1) begin
            errors++;
            $display("FAIL sh_resp: valid=%b expected 1", bus.resp_valid);
        end
    endtask

    task automatic test_flush_access();
        int respCnt = 0;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SW;
        bus.req_addr  = 32'h90;
        bus.req_wdata = 32'h1234_5678;
        @(negedge clk);
        idle_inputs();
        bus.req_flush = 1'b1;
        #1;
        checks++;
        if (bus.mem_en !== 1'b1 || bus.mem_wen !== 4'b1111 || bus.stall_o !== 1'b1) begin
            errors++;
            $display("FAIL flush_sw_issue: en=%b wen=%b stall=%b expected 1/1111/1",
                     bus.mem_en, bus.mem_wen, bus.stall_o);
        end
        @(negedge clk);
        bus.req_flush = 1'b0;
        #1;
        checks++;
        if (!(bus.mem_en === 1'b1 && bus.mem_wen === 4'b1111 &&
              bus.mem_wdata === 32'h1234_5678 && bus.stall_o === 1'b1)) begin
            errors++;
            $display("FAIL flush_sw_hold: en=%b wen=%b wdata=%h stall=%b expected 1/1111/12345678/1",
                     bus.mem_en, bus.mem_wen, bus.mem_wdata, bus.stall_o);
        end
        @(negedge clk);
        bus.mem_ready = 1'b1;
        #1;
        checks++;
        if (bus.stall_o !== 1'b1 || bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL flush_sw_complete: stall=%b en=%b expected 1/1", bus.stall_o, bus.mem_en);
        end
        @(negedge clk);
        bus.mem_ready = 1'b0;
        #1;
        checks++;
        if (bus.stall_o !== 1'b0 || bus.mem_en !== 1'b0) begin
            errors++;
            $display("FAIL flush_sw_release: stall=%b en=%b expected 0/0", bus.stall_o, bus.mem_en);
        end
        for (int c = 0; c < 3; c++) begin
            if (bus.resp_valid || bus.bus_err) respCnt++;
            @(negedge clk);
            #1;
        end
        checks++;
        if (respCnt != 0) begin
            errors++;
            $display("FAIL flush_sw_noresp: pulses=%0d expected 0", respCnt);
        end
    endtask

    task automatic test_rst_mid();
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_LW;
        bus.req_addr  = 32'hA0;
        @(negedge clk);
        idle_inputs();
        #1;
        checks++;
        if (bus.mem_en !== 1'b1) begin
            errors++;
            $display("FAIL rst_mid_pre: en=%b expected 1", bus.mem_en);
        end
        @(negedge clk);
        rst = 1'b1;
        bus.mem_ready = 1'b1;
        bus.mem_rdata = 32'h5555_5555;
        @(negedge clk);
        #1;
        checks++;
        if ({bus.mem_en, bus.stall_o, bus.resp_valid} !== 3'b000) begin
            errors++;
            $display("FAIL rst_mid: en/stall/valid=%b expected 000",
                     {bus.mem_en, bus.stall_o, bus.resp_valid});
        end
        @(negedge clk);
        rst = 1'b0;
        idle_inputs();
        #1;
        checks++;
        if ({bus.mem_en, bus.stall_o, bus.resp_valid} !== 3'b000 || bus.resp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_after: en/stall/valid=%b rdata=%h expected 000/00000000",
                     {bus.mem_en, bus.stall_o, bus.resp_valid}, bus.resp_rdata);
        end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_lw_wait();
        test_sb();
        test_load_extend();
        test_flush_load();
        test_misalign();
        test_ignored();
        test_timeout();
        test_back_to_back();
        test_flush_access();
        test_rst_mid();
        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/lsu_handshake.md
Name: lsu_handshake

Overview:
- Parametrised load/store unit for the MIPS pipeline's M stage.
- Generalises the combinational byte-select and alignment-check path into a multi-cycle, handshaked data-memory access: variable memory latency, timeout, flush and pipeline stall.
- Sits between the datapath (opcode, address, store data, load result) and the data SRAM-like bus.

Parameters:
- ADDR_W, 32, byte address width.
- TIMEOUT_CYC, 16, maximum cycles to wait for mem_ready before bus_err; minimum 1.
- CNT_W, 5, timeout counter width; must satisfy 2^CNT_W > TIMEOUT_CYC.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  1  M-stage memory instruction present.
- req_op  in  6  MIPS opcode: LB 100000, LBU 100100, LH 100001, LHU 100101, LW 100011, SB 101000, SH 101001, SW 101011.
- req_addr  in  ADDR_W  effective byte address.
- req_wdata  in  32  store data, right-aligned.
- req_flush  in  1  exception flush of the current M instruction.
- stall_o  out  1  pipeline stall request.
- resp_valid  out  1  one-cycle load-result or store-complete pulse.
- resp_rdata  out  32  sign- or zero-extended load result.
- adel  out  1  load address error pulse.
- ades  out  1  store address error pulse.
- bus_err  out  1  timeout pulse.
- mem_en  out  1  memory request.
- mem_wen  out  4  byte write enables.
- mem_addr  out  ADDR_W  word-aligned address; low 2 bits are 0.
- mem_wdata  out  32  lane-replicated store data.
- mem_rdata  in  32  read data, valid when mem_ready is high.
- mem_ready  in  1  memory completion.

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; counter 0.
- States: IDLE, ACCESS, RESP.
- IDLE, valid legal op, aligned:
  - Latch op, addr, wdata and address lanes.
  - Go to ACCESS; stall_o is high combinationally in this cycle.
- IDLE, valid legal op, misaligned (halfword addr[0]=1; word addr[1:0]!=0):
  - No memory access.
  - Next cycle: adel (loads) or ades (stores) = 1 for one cycle; stall_o stays 0.
- IDLE, non-memory opcode: ignored, no response.
- ACCESS:
  - mem_en=1 and mem_addr, mem_wen, mem_wdata are held stable until mem_ready.
  - stall_o=1; the counter increments each cycle.
- ACCESS, mem_ready=1:
  - Capture and extend mem_rdata; go to RESP.
  - mem_en drops in the next cycle.
- ACCESS, counter reaches TIMEOUT_CYC without mem_ready:
  - bus_err=1 for one cycle; go to IDLE; stall_o drops.
  - mem_ready has priority when both occur in the same cycle.
- RESP: resp_valid=1 for one cycle, stall_o=0, then IDLE. A new request is accepted only in IDLE.
- Byte enables and store data:
  - SB: mem_wen = 1 << addr[1:0]; data byte replicated to all four lanes.
  - SH: mem_wen = 0011 or 1100 by addr[1]; halfword replicated to both halves.
  - SW: mem_wen = 1111.
  - Loads: mem_wen = 0000.
- Load extraction: select the byte or halfword lane by the latched addr[1:0], then extend.
  - LB/LH: sign-extend.
  - LBU/LHU: zero-extend.
- Flush:
  - req_flush in IDLE with req_valid suppresses acceptance and the exception pulse.
  - req_flush during ACCESS sets a sticky cancel flag. The bus transaction still completes, because stores already issued cannot be withdrawn. resp_valid and bus_err are suppressed and resp_rdata is not updated.
  - stall_o holds until ACCESS exits.
- rst mid-ACCESS: returns to IDLE immediately and drops mem_en. The memory side must tolerate an abandoned request.

Decomposition:
- Shared package mips_mem_pkg holds:
  - opcode localparams (OP_LB … OP_SW);
  - the state encoding (IDLE=2'd0, ACCESS=2'd1, RESP=2'd2);
  - a size enum (BYTE, HALF, WORD).
- One natural sub-module, lsu_lane_align: purely combinational wen/wdata replication, read extraction and alignment check. It is reused by the instruction-fetch path.

Test Plan:
- LW at 0x0000_0010, memory returns 0xDEADBEEF after 3 wait cycles:
  - stall_o high for 4 cycles (accept cycle plus 3 ACCESS cycles);
  - resp_valid once with resp_rdata=0xDEADBEEF.
- SB 0x000000A5 at 0x...03, mem_ready same cycle:
  - mem_wen=1000, mem_wdata=0xA5A5A5A5, mem_addr=0x...00;
  - resp_valid in the next cycle.
- LB at 0x...02 with mem_rdata=0x0080_0000 → resp_rdata=0xFFFFFF80.
- LBU at 0x...02 with the same data → resp_rdata=0x00000080.
- LH at 0x...01 → adel pulse one cycle later, mem_en never asserted.
- SW at 0x...02 → ades pulse, same rules.
- mem_ready never asserted:
  - bus_err pulses when the counter reaches TIMEOUT_CYC (counter increments each ACCESS cycle, bus_err in the cycle it reaches 16);
  - FSM returns to IDLE.
- req_flush one cycle into an SW access:
  - store still written with mem_wen=1111;
  - resp_valid suppressed; stall_o released after mem_ready.
- rst asserted mid-ACCESS → mem_en, stall_o and resp_valid all 0 on the next edge.
